// File: rtl/matrix_loader_pkg.sv
// Shared types and constants for the matrix loader: FSM states, frame
// geometry and a helper for sizing the wait counter.
package matrix_loader_pkg;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        LOAD    = 2'd1,
        WAIT_LO = 2'd2,
        WAIT_HI = 2'd3
    } state_t;

    localparam int N_ELEMS    = 18;  // 9 A elements followed by 9 B elements
    localparam int B_BASE     = 9;   // first stream index that lands in B
    localparam int DEF_DATA_W = 8;   // element width of the 3x3 multiplier
    localparam int IDX_W      = 5;   // enough bits for fill_idx 0..17

    // Bits needed to hold values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/matrix_loader_if.sv
// Bundle of the byte-stream handshake, the operand bus to the multiplier and
// the loader status signals. master = loader side, slave = environment side.
interface matrix_loader_if
    import matrix_loader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    logic [DATA_W-1:0] A00, A01, A02, A10, A11, A12, A20, A21, A22;
    logic [DATA_W-1:0] B00, B01, B02, B10, B11, B12, B20, B21, B22;

    logic              mat_load;
    logic              mat_done;

    logic              busy;
    logic [IDX_W-1:0]  fill_idx;
    logic              done_pulse;
    logic              err;

    modport master (
        input  in_data, in_valid, mat_done,
        output in_ready,
        output A00, A01, A02, A10, A11, A12, A20, A21, A22,
        output B00, B01, B02, B10, B11, B12, B20, B21, B22,
        output mat_load, busy, fill_idx, done_pulse, err
    );

    modport slave (
        output in_data, in_valid, mat_done,
        input  in_ready,
        input  A00, A01, A02, A10, A11, A12, A20, A21, A22,
        input  B00, B01, B02, B10, B11, B12, B20, B21, B22,
        input  mat_load, busy, fill_idx, done_pulse, err
    );

endinterface

// File: rtl/matrix_loader_wait_timer.sv
// Clearable up-counter used as the multiplier watchdog. o_tc flags that
// WAIT_MAX wait cycles have been spent (count == WAIT_MAX-1).
module matrix_loader_wait_timer
    import matrix_loader_pkg::*;
#(
    parameter int WAIT_MAX = 255
) (
    input  logic clk,
    input  logic Reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);
    localparam int CNT_W = cnt_width(WAIT_MAX);

    logic [CNT_W-1:0] r_cnt;

    // Count enabled cycles; clear wins, and the count parks at terminal.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_tc) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_tc = (r_cnt == CNT_W'(WAIT_MAX - 1));

endmodule

// File: rtl/matrix_loader.sv
// Feeder for the 3x3 multiplier: collects an 18-byte frame (A then B,
// row-major), strobes Load, then holds operands until Done goes low and
// back high. A watchdog aborts a compute that never finishes.
module matrix_loader
    import matrix_loader_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,  // must equal the interface DATA_W
    parameter int WAIT_MAX = 255
) (
    input  logic           clk,
    input  logic           Reset,
    matrix_loader_if.master bus
);
    state_t            r_state;
    state_t            w_next;
    logic [IDX_W-1:0]  r_fill_idx;
    logic [DATA_W-1:0] r_elem [N_ELEMS];
    logic              r_mat_load;
    logic              r_done_pulse;
    logic              r_err;

    logic              w_in_ready;
    logic              w_xfer;
    logic              w_last;
    logic              w_in_wait;
    logic              w_tc;
    logic              w_timeout;
    logic              w_complete;

    assign w_in_ready = (r_state == FILL) && !Reset;
    assign w_xfer     = bus.in_valid && w_in_ready;
    assign w_last     = (r_fill_idx == IDX_W'(N_ELEMS - 1));
    assign w_in_wait  = (r_state == WAIT_LO) || (r_state == WAIT_HI);

    // Watchdog restarts in LOAD so each compute gets the full WAIT_MAX budget.
    matrix_loader_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk   (clk),
        .Reset (Reset),
        .i_clr (r_state == LOAD),
        .i_en  (w_in_wait),
        .o_tc  (w_tc)
    );

    // Next-state logic; a completing Done takes priority over the watchdog.
    always_comb begin
        w_next     = r_state;
        w_timeout  = 1'b0;
        w_complete = 1'b0;
        case (r_state)
            FILL: begin
                if (w_xfer && w_last) w_next = LOAD;
            end
            LOAD: begin
                w_next = WAIT_LO;
            end
            WAIT_LO: begin
                // Done may still be high from idle; wait for it to drop.
                if (w_tc) begin
                    w_next    = FILL;
                    w_timeout = 1'b1;
                end else if (!bus.mat_done) begin
                    w_next = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (bus.mat_done) begin
                    w_next     = FILL;
                    w_complete = 1'b1;
                end else if (w_tc) begin
                    w_next    = FILL;
                    w_timeout = 1'b1;
                end
            end
            default: begin
                w_next = FILL;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) r_state <= FILL;
        else       r_state <= w_next;
    end

    // Registered Load/done strobes and the sticky watchdog error.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_mat_load   <= 1'b0;
            r_done_pulse <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_mat_load   <= (w_next == LOAD);
            r_done_pulse <= w_complete;
            r_err        <= r_err | w_timeout;
        end
    end

    // Operand capture: only FILL transfers write, so operands hold during compute.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_fill_idx <= '0;
            for (int i = 0; i < N_ELEMS; i++) r_elem[i] <= '0;
        end else if (w_xfer) begin
            r_elem[r_fill_idx] <= bus.in_data;
            r_fill_idx         <= w_last ? '0 : r_fill_idx + IDX_W'(1);
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.mat_load   = r_mat_load;
    assign bus.busy       = (r_state != FILL);
    assign bus.fill_idx   = r_fill_idx;
    assign bus.done_pulse = r_done_pulse;
    assign bus.err        = r_err;

    assign bus.A00 = r_elem[0];
    assign bus.A01 = r_elem[1];
    assign bus.A02 = r_elem[2];
    assign bus.A10 = r_elem[3];
    assign bus.A11 = r_elem[4];
    assign bus.A12 = r_elem[5];
    assign bus.A20 = r_elem[6];
    assign bus.A21 = r_elem[7];
    assign bus.A22 = r_elem[8];
    assign bus.B00 = r_elem[B_BASE + 0];
    assign bus.B01 = r_elem[B_BASE + 1];
    assign bus.B02 = r_elem[B_BASE + 2];
    assign bus.B10 = r_elem[B_BASE + 3];
    assign bus.B11 = r_elem[B_BASE + 4];
    assign bus.B12 = r_elem[B_BASE + 5];
    assign bus.B20 = r_elem[B_BASE + 6];
    assign bus.B21 = r_elem[B_BASE + 7];
    assign bus.B22 = r_elem[B_BASE + 8];

endmodule

// File: tb/tb_matrix_loader.sv
// Bench for matrix_loader: two instances (WAIT_MAX 255 and 16) share one
// stimulus stream; a frame-level model predicts every output each cycle.
module tb_matrix_loader;
    import matrix_loader_pkg::*;

    localparam int DW  = 8;
    localparam int WM0 = 255;
    localparam int WM1 = 16;

    logic          clk;
    logic          Reset;
    logic [DW-1:0] tb_data;
    logic          tb_valid;
    logic          tb_done;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 0;
    int load_cnt0 = 0;
    int done_cnt0 = 0;

    int mul_lo   = 1;
    int mul_hi   = 3;
    bit mul_hold = 0;

    matrix_loader_if #(.DATA_W(DW)) bus0 ();
    matrix_loader_if #(.DATA_W(DW)) bus1 ();

    assign bus0.in_data  = tb_data;
    assign bus0.in_valid = tb_valid;
    assign bus0.mat_done = tb_done;
    assign bus1.in_data  = tb_data;
    assign bus1.in_valid = tb_valid;
    assign bus1.mat_done = tb_done;

    matrix_loader #(.DATA_W(DW), .WAIT_MAX(WM0)) dut0 (.clk(clk), .Reset(Reset), .bus(bus0));
    matrix_loader #(.DATA_W(DW), .WAIT_MAX(WM1)) dut1 (.clk(clk), .Reset(Reset), .bus(bus1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Flattened view of each instance's outputs.
    logic [18*8-1:0] a_ops [2];
    logic            a_rdy [2];
    logic            a_busy[2];
    logic            a_load[2];
    logic            a_dp  [2];
    logic            a_err [2];
    logic [4:0]      a_idx [2];

    assign a_ops[0] = {bus0.A00, bus0.A01, bus0.A02, bus0.A10, bus0.A11, bus0.A12,
                       bus0.A20, bus0.A21, bus0.A22, bus0.B00, bus0.B01, bus0.B02,
                       bus0.B10, bus0.B11, bus0.B12, bus0.B20, bus0.B21, bus0.B22};
    assign a_ops[1] = {bus1.A00, bus1.A01, bus1.A02, bus1.A10, bus1.A11, bus1.A12,
                       bus1.A20, bus1.A21, bus1.A22, bus1.B00, bus1.B01, bus1.B02,
                       bus1.B10, bus1.B11, bus1.B12, bus1.B20, bus1.B21, bus1.B22};
    assign a_rdy[0]  = bus0.in_ready;   assign a_rdy[1]  = bus1.in_ready;
    assign a_busy[0] = bus0.busy;       assign a_busy[1] = bus1.busy;
    assign a_load[0] = bus0.mat_load;   assign a_load[1] = bus1.mat_load;
    assign a_dp[0]   = bus0.done_pulse; assign a_dp[1]   = bus1.done_pulse;
    assign a_err[0]  = bus0.err;        assign a_err[1]  = bus1.err;
    assign a_idx[0]  = bus0.fill_idx;   assign a_idx[1]  = bus1.fill_idx;

    function automatic logic [7:0] op(input int k, input int e);
        return a_ops[k][(17-e)*8 +: 8];
    endfunction

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (%0d) at %0t: actual %0h required %0h", nm, id, $time, act, exp);
        end
    endtask

    // Frame-level model: bytes accepted in frame order, then a busy period
    // counted in cycles; completion needs Done seen low, then high.
    logic [7:0] m_elem[2][18];
    int         m_idx [2];
    bit         m_busy[2];
    int         m_cyc [2];
    bit         m_lo  [2];
    bit         m_dp  [2];
    bit         m_err [2];

    always @(posedge clk or posedge Reset) begin
        for (int k = 0; k < 2; k++) begin
            if (Reset) begin
                m_idx[k]  <= 0;
                m_busy[k] <= 0;
                m_cyc[k]  <= 0;
                m_lo[k]   <= 0;
                m_dp[k]   <= 0;
                m_err[k]  <= 0;
                for (int e = 0; e < 18; e++) m_elem[k][e] <= 8'h00;
            end else begin
                m_dp[k] <= 0;
                if (!m_busy[k]) begin
                    if (tb_valid) begin
                        m_elem[k][m_idx[k]] <= tb_data;
                        if (m_idx[k] == 17) begin
                            m_idx[k]  <= 0;
                            m_busy[k] <= 1;
                            m_cyc[k]  <= 0;
                            m_lo[k]   <= 0;
                        end else begin
                            m_idx[k] <= m_idx[k] + 1;
                        end
                    end
                end else if (m_cyc[k] == 0) begin
                    m_cyc[k] <= 1;
                end else if (m_lo[k] && tb_done) begin
                    m_busy[k] <= 0;
                    m_dp[k]   <= 1;
                end else if (m_cyc[k] == ((k == 0) ? WM0 : WM1)) begin
                    m_busy[k] <= 0;
                    m_err[k]  <= 1;
                end else begin
                    if (!tb_done) m_lo[k] <= 1;
                    m_cyc[k] <= m_cyc[k] + 1;
                end
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk("in_ready",   k, 32'(a_rdy[k]),  32'(!m_busy[k] && !Reset));
                chk("busy",       k, 32'(a_busy[k]), 32'(m_busy[k]));
                chk("fill_idx",   k, 32'(a_idx[k]),  32'(m_idx[k]));
                chk("mat_load",   k, 32'(a_load[k]), 32'(m_busy[k] && m_cyc[k] == 0));
                chk("done_pulse", k, 32'(a_dp[k]),   32'(m_dp[k]));
                chk("err",        k, 32'(a_err[k]),  32'(m_err[k]));
                for (int e = 0; e < 18; e++)
                    chk("operand", k*100 + e, 32'(op(k, e)), 32'(m_elem[k][e]));
            end
        end
    end

    always @(negedge clk) begin
        if (bus0.mat_load)   load_cnt0 <= load_cnt0 + 1;
        if (bus0.done_pulse) done_cnt0 <= done_cnt0 + 1;
    end

    // Multiplier stand-in: Done idles high, drops mul_lo cycles after Load,
    // rises mul_hi cycles later; mul_hold keeps it high forever.
    initial begin
        tb_done = 1'b1;
        forever begin
            @(negedge clk);
            if (bus0.mat_load && !mul_hold) begin
                repeat (mul_lo) @(posedge clk);
                #2 tb_done = 1'b0;
                repeat (mul_hi) @(posedge clk);
                #2 tb_done = 1'b1;
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, output bit pulse_seen);
        int n   = 0;
        bit acc = 0;
        pulse_seen = 0;
        tb_valid = 1'b1;
        tb_data  = d;
        while (!acc && n < 400) begin
            @(negedge clk);
            acc        = bus0.in_ready;
            pulse_seen = bus0.done_pulse;
            @(posedge clk);
            #2;
            n++;
        end
        chk("byte_accepted", 0, 32'(acc), 32'd1);
    endtask

    task automatic send_frame(input logic [7:0] base, input int step, input bit gapped);
        bit p;
        for (int i = 0; i < 18; i++) begin
            send_byte(8'(int'(base) + i*step), p);
            if (gapped && i < 17) begin
                tb_valid = 1'b0;
                @(posedge clk);
                #2;
            end
        end
        tb_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n    = 0;
        bit seen = 0;
        while (!seen && n < budget) begin
            @(negedge clk);
            seen = bus0.done_pulse;
            n++;
        end
        chk("done_pulse_seen", 0, 32'(seen), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: actual running required finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        bit p;
        int n;
        Reset    = 1'b1;
        tb_valid = 1'b0;
        tb_data  = 8'h00;
        repeat (2) @(posedge clk);
        #2 chk_en = 1;
        @(posedge clk);
        #2 Reset = 1'b0;
        @(negedge clk);
        chk("rst_fill_idx", 0, 32'(bus0.fill_idx), 32'd0);
        chk("rst_in_ready", 0, 32'(bus0.in_ready), 32'd1);
        chk("rst_A00",      0, 32'(bus0.A00),      32'd0);
        chk("rst_err",      0, 32'(bus0.err),      32'd0);
        @(posedge clk);
        #2;

        // Frame 1..18 into a slow multiplier (dut1 times out on it).
        mul_lo = 2;
        mul_hi = 30;
        send_frame(8'd1, 1, 0);
        @(negedge clk);
        chk("t1_load_hi", 0, 32'(bus0.mat_load), 32'd1);
        chk("t1_busy",    0, 32'(bus0.busy),     32'd1);
        @(negedge clk);
        chk("t1_load_lo", 0, 32'(bus0.mat_load), 32'd0);
        chk("t1_A00", 0, 32'(op(0, 0)),  32'd1);
        chk("t1_A22", 0, 32'(op(0, 8)),  32'd9);
        chk("t1_B00", 0, 32'(op(0, 9)),  32'd10);
        chk("t1_B22", 0, 32'(op(0, 17)), 32'd18);
        wait_done(200);
        @(posedge clk);
        #2;
        chk("t1_load_cnt", 0, 32'(load_cnt0), 32'd1);
        chk("t1_done_cnt", 0, 32'(done_cnt0), 32'd1);
        chk("t1_A11_kept", 0, 32'(op(0, 4)),  32'd5);
        chk("t1_err0",     0, 32'(bus0.err),  32'd0);
        chk("t1_err1",     1, 32'(bus1.err),  32'd1);

        // Gapped 0xFF frame.
        mul_lo = 1;
        mul_hi = 3;
        send_frame(8'hFF, 0, 1);
        @(negedge clk);
        chk("t3_load_hi", 0, 32'(bus0.mat_load), 32'd1);
        wait_done(100);
        @(posedge clk);
        #2;
        chk("t3_A11", 0, 32'(op(0, 4)),  32'hFF);
        chk("t3_B22", 0, 32'(op(0, 17)), 32'hFF);
        chk("t3_load_cnt", 0, 32'(load_cnt0), 32'd2);
        chk("t3_done_cnt", 0, 32'(done_cnt0), 32'd2);

        // Back-to-back frames: second frame's first byte waits for done_pulse.
        for (int i = 0; i < 18; i++) send_byte(8'(8'h20 + i), p);
        send_byte(8'h40, p);
        chk("t6_accept_on_pulse", 0, 32'(p), 32'd1);
        for (int i = 1; i < 18; i++) send_byte(8'(8'h40 + i), p);
        tb_valid = 1'b0;
        @(negedge clk);
        chk("t6_load_hi", 0, 32'(bus0.mat_load), 32'd1);
        wait_done(100);
        @(posedge clk);
        #2;
        chk("t6_A00", 0, 32'(op(0, 0)),  32'h40);
        chk("t6_B22", 0, 32'(op(0, 17)), 32'h51);
        chk("t6_load_cnt", 0, 32'(load_cnt0), 32'd4);
        chk("t6_done_cnt", 0, 32'(done_cnt0), 32'd4);

        // Reset after 7 transfers of 0xA5, then a fresh frame.
        for (int i = 0; i < 7; i++) send_byte(8'hA5, p);
        tb_valid = 1'b0;
        Reset    = 1'b1;
        repeat (2) @(posedge clk);
        #2 Reset = 1'b0;
        @(negedge clk);
        chk("t5_A00",      0, 32'(op(0, 0)),      32'd0);
        chk("t5_A20",      0, 32'(op(0, 6)),      32'd0);
        chk("t5_fill_idx", 0, 32'(bus0.fill_idx), 32'd0);
        chk("t5_in_ready", 0, 32'(bus0.in_ready), 32'd1);
        chk("t5_err1",     1, 32'(bus1.err),      32'd0);
        @(posedge clk);
        #2;
        send_frame(8'd3, 3, 0);
        @(negedge clk);
        chk("t5_load_hi", 0, 32'(bus0.mat_load), 32'd1);
        wait_done(100);
        @(posedge clk);
        #2;
        chk("t5_A00_new", 0, 32'(op(0, 0)),  32'd3);
        chk("t5_B11_new", 0, 32'(op(0, 13)), 32'd42);

        // Done stuck high: dut1 times out after 16 wait cycles, dut0 after 255.
        mul_hold = 1;
        send_frame(8'h10, 1, 0);
        @(negedge clk);
        chk("t4_load_hi", 1, 32'(bus1.mat_load), 32'd1);
        repeat (16) @(negedge clk);
        chk("t4_err_before", 1, 32'(bus1.err),  32'd0);
        chk("t4_busy_before", 1, 32'(bus1.busy), 32'd1);
        @(negedge clk);
        chk("t4_err_after",  1, 32'(bus1.err),        32'd1);
        chk("t4_busy_after", 1, 32'(bus1.busy),       32'd0);
        chk("t4_no_pulse",   1, 32'(bus1.done_pulse), 32'd0);
        n = 0;
        while (bus0.busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("t4_dut0_exit", 0, 32'(bus0.busy), 32'd0);
        chk("t4_dut0_err",  0, 32'(bus0.err),  32'd1);
        @(posedge clk);
        #2;
        chk("t4_done_cnt", 0, 32'(done_cnt0), 32'd5);
        chk("t4_load_cnt", 0, 32'(load_cnt0), 32'd6);
        mul_hold = 0;
        send_frame(8'h80, 1, 0);
        @(negedge clk);
        chk("t4_good_load", 0, 32'(bus0.mat_load), 32'd1);
        wait_done(100);
        @(posedge clk);
        #2;
        chk("t4_err0_sticky", 0, 32'(bus0.err), 32'd1);
        chk("t4_err1_sticky", 1, 32'(bus1.err), 32'd1);
        chk("t4_good_done",   0, 32'(done_cnt0), 32'd6);
        chk("t4_good_B22",    0, 32'(op(0, 17)), 32'h91);

        repeat (3) @(posedge clk);
        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
